// File: rtl/systolic_pe_v2.sv
// Weight-stationary systolic processing element with a background weight
// buffer. Activations flow west->east, partial sums and weights flow
// north->south. The active weight is replaced from a circular buffer of
// preloaded slots on switch_in, so the next weight tile can stream in
// while the current one is still in use. The datapath is fixed-point with
// two saturation stages: after the product and after the accumulate.
module systolic_pe_v2 #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [DATA_WIDTH-1:0]             psum_in,
  input  logic [DATA_WIDTH-1:0]             weight_in,
  input  logic                              accept_w_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              valid_in,
  input  logic                              switch_in,
  output logic [DATA_WIDTH-1:0]             psum_out,
  output logic [DATA_WIDTH-1:0]             weight_out,
  output logic                              accept_w_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              valid_out,
  output logic                              switch_out,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count,
  output logic                              sat_flag,
  output logic                              wbuf_err
);

  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WBUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WBUF_DEPTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] slots [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] active_w;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                    do_read;
  logic                    do_write;
  logic                    buf_err;
  logic [CNT_W-1:0]        count_next;
  logic [2*DATA_WIDTH-1:0] prod_full;
  logic [2*DATA_WIDTH-1:0] prod_shift;
  logic [DATA_WIDTH-1:0]   prod_sat;
  logic [DATA_WIDTH:0]     sum_ext;
  logic [DATA_WIDTH-1:0]   sum_sat;
  logic                    sat_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffer control: a switch frees the read slot, so a simultaneous write
  // is still accepted when the buffer is full.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    do_read    = 1'b0;
    do_write   = 1'b0;
    buf_err    = 1'b0;
    count_next = wbuf_count;
    do_read    = switch_in && (wbuf_count != '0);
    do_write   = accept_w_in && ((wbuf_count != CNT_FULL) || do_read);
    buf_err    = (accept_w_in && !do_write) || (switch_in && (wbuf_count == '0));
    if (do_write && !do_read)      count_next = wbuf_count + CNT_W'(1);
    else if (!do_write && do_read) count_next = wbuf_count - CNT_W'(1);
  end

  // Fixed-point multiply-accumulate with saturation after each stage.
  always_comb begin
    prod_full  = '0;
    prod_shift = '0;
    prod_sat   = '0;
    sum_ext    = '0;
    sum_sat    = '0;
    sat_hit    = 1'b0;
    prod_full  = $signed({{DATA_WIDTH{data_out[DATA_WIDTH-1]}}, data_out}) *
                 $signed({{DATA_WIDTH{active_w[DATA_WIDTH-1]}}, active_w});
    prod_shift = $signed(prod_full) >>> FRAC_BITS;
    // The shifted product fits only if all bits above the target sign bit
    // replicate it.
    if (prod_shift[2*DATA_WIDTH-1:DATA_WIDTH-1] == '0 ||
        prod_shift[2*DATA_WIDTH-1:DATA_WIDTH-1] == '1) begin
      prod_sat = prod_shift[DATA_WIDTH-1:0];
    end else begin
      prod_sat = prod_shift[2*DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
      sat_hit  = 1'b1;
    end
    sum_ext = {prod_sat[DATA_WIDTH-1], prod_sat} + {psum_in[DATA_WIDTH-1], psum_in};
    if (sum_ext[DATA_WIDTH] == sum_ext[DATA_WIDTH-1]) begin
      sum_sat = sum_ext[DATA_WIDTH-1:0];
    end else begin
      sum_sat = sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      sat_hit = 1'b1;
    end
  end

  // Forwarded and computed outputs, cleared by reset or by en low.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      psum_out     <= '0;
      weight_out   <= '0;
      accept_w_out <= 1'b0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      switch_out   <= 1'b0;
      sat_flag     <= 1'b0;
      wbuf_err     <= 1'b0;
    end else if (!en) begin
      psum_out     <= '0;
      weight_out   <= '0;
      accept_w_out <= 1'b0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      switch_out   <= 1'b0;
      sat_flag     <= 1'b0;
      wbuf_err     <= 1'b0;
    end else begin
      psum_out     <= sum_sat;
      weight_out   <= accept_w_in ? weight_in : '0;
      accept_w_out <= accept_w_in;
      if (valid_in) data_out <= data_in;
      valid_out    <= valid_in;
      switch_out   <= switch_in;
      sat_flag     <= sat_flag | sat_hit;
      wbuf_err     <= wbuf_err | buf_err;
    end
  end

  // Weight buffer, pointers, count and active weight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the slot array is deliberately cleared on reset: no stale weight
    // may survive a reset or disable, so it cannot map to a plain RAM.
    if (rst) begin
      for (int i = 0; i < WBUF_DEPTH; i++) slots[i] <= '0;
      active_w   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wbuf_count <= '0;
    end else if (!en) begin
      for (int i = 0; i < WBUF_DEPTH; i++) slots[i] <= '0;
      active_w   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wbuf_count <= '0;
    end else begin
      if (do_read) begin
        active_w <= slots[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      if (do_write) begin
        slots[wr_ptr] <= weight_in;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      wbuf_count <= count_next;
    end
  end

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Self-checking bench for systolic_pe_v2: directed scenarios followed by a
// random phase, all compared each cycle against a queue-based reference.
module tb_systolic_pe_v2;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int WD = 2;
  localparam int CW = $clog2(WD + 1);
  localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] psum_in, weight_in, data_in;
  logic          accept_w_in, valid_in, switch_in;
  logic [DW-1:0] psum_out, weight_out, data_out;
  logic          accept_w_out, valid_out, switch_out;
  logic [CW-1:0] wbuf_count;
  logic          sat_flag, wbuf_err;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference state
  logic [DW-1:0] m_psum, m_wout, m_data, m_active;
  logic          m_acc, m_valid, m_switch, m_sat, m_err;
  logic [DW-1:0] m_q[$];

  systolic_pe_v2 #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .WBUF_DEPTH(WD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .psum_in(psum_in), .weight_in(weight_in), .accept_w_in(accept_w_in),
    .data_in(data_in), .valid_in(valid_in), .switch_in(switch_in),
    .psum_out(psum_out), .weight_out(weight_out), .accept_w_out(accept_w_out),
    .data_out(data_out), .valid_out(valid_out), .switch_out(switch_out),
    .wbuf_count(wbuf_count), .sat_flag(sat_flag), .wbuf_err(wbuf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_psum = '0; m_wout = '0; m_data = '0; m_active = '0;
    m_acc = 0; m_valid = 0; m_switch = 0; m_sat = 0; m_err = 0;
    m_q.delete();
  endtask

  function automatic longint clamp(input longint v, inout logic hit);
    if (v > MAXV) begin hit = 1'b1; return MAXV; end
    if (v < MINV) begin hit = 1'b1; return MINV; end
    return v;
  endfunction

  // One enabled cycle of behaviour, written from the block's rules.
  task automatic model_step();
    longint p, s;
    logic   hit;
    int     cnt;
    bit     rd, wr;
    if (!en) begin
      model_clear();
      return;
    end
    hit = 1'b0;
    p = (longint'($signed(m_data)) * longint'($signed(m_active))) >>> FB;
    p = clamp(p, hit);
    s = clamp(p + longint'($signed(psum_in)), hit);
    m_psum = s[DW-1:0];
    m_sat  = m_sat | hit;
    cnt = m_q.size();
    rd  = switch_in && cnt > 0;
    wr  = accept_w_in && (cnt < WD || rd);
    if (rd) m_active = m_q.pop_front();
    if (wr) m_q.push_back(weight_in);
    m_err    = m_err | (accept_w_in && !wr) | (switch_in && cnt == 0);
    m_wout   = accept_w_in ? weight_in : '0;
    m_acc    = accept_w_in;
    m_valid  = valid_in;
    m_switch = switch_in;
    if (valid_in) m_data = data_in;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".psum_out"},     32'(psum_out),     32'(m_psum));
    chk({ctx, ".weight_out"},   32'(weight_out),   32'(m_wout));
    chk({ctx, ".accept_w_out"}, 32'(accept_w_out), 32'(m_acc));
    chk({ctx, ".data_out"},     32'(data_out),     32'(m_data));
    chk({ctx, ".valid_out"},    32'(valid_out),    32'(m_valid));
    chk({ctx, ".switch_out"},   32'(switch_out),   32'(m_switch));
    chk({ctx, ".wbuf_count"},   32'(wbuf_count),   32'(m_q.size()));
    chk({ctx, ".sat_flag"},     32'(sat_flag),     32'(m_sat));
    chk({ctx, ".wbuf_err"},     32'(wbuf_err),     32'(m_err));
  endtask

  // Drive one cycle of inputs, clock it, update the reference, compare.
  task automatic step(input string ctx, input logic e, input logic acc, input logic [DW-1:0] w,
                      input logic v, input logic [DW-1:0] d, input logic sw,
                      input logic [DW-1:0] p);
    en = e; accept_w_in = acc; weight_in = w; valid_in = v; data_in = d;
    switch_in = sw; psum_in = p;
    @(posedge clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  task automatic clear_cycle(input string ctx);
    step(ctx, 0, 0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; psum_in = '0; weight_in = '0; data_in = '0;
    accept_w_in = 0; valid_in = 0; switch_in = 0;
    model_clear();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Q8.8 MAC: 1.5 * 2.0 + 1.0 = 4.0
    step("mac_load",   1, 1, 16'h0200, 0, '0,       0, '0);
    step("mac_switch", 1, 0, '0,       0, '0,       1, '0);
    step("mac_data",   1, 0, '0,       1, 16'h0180, 0, '0);
    step("mac_psum",   1, 0, '0,       0, '0,       0, 16'h0100);
    chk("mac_result", 32'(psum_out), 32'h0400);
    chk("mac_nosat",  32'(sat_flag), 32'h0);

    // Overfill, then drain in order
    clear_cycle("clr1");
    step("fill1", 1, 1, 16'h0100, 1, 16'h0100, 0, '0);
    step("fill2", 1, 1, 16'h0200, 0, '0,       0, '0);
    step("fill3", 1, 1, 16'h0300, 0, '0,       0, '0);
    chk("overfill_count", 32'(wbuf_count), 32'd2);
    chk("overfill_err",   32'(wbuf_err),   32'd1);
    step("drain1", 1, 0, '0, 0, '0, 1, '0);
    step("drain2", 1, 0, '0, 0, '0, 1, '0);
    chk("drain_w1", 32'(psum_out), 32'h0100);
    step("drain3", 1, 0, '0, 0, '0, 0, '0);
    chk("drain_w2", 32'(psum_out), 32'h0200);
    chk("drain_empty", 32'(wbuf_count), 32'd0);

    // Switch on empty buffer
    clear_cycle("clr2");
    step("empty_sw", 1, 0, '0, 1, 16'h0100, 1, '0);
    chk("empty_sw_err", 32'(wbuf_err), 32'd1);
    step("empty_sw_hold", 1, 0, '0, 0, '0, 0, 16'h0011);
    chk("empty_sw_w0", 32'(psum_out), 32'h0011);
    // Accept and switch together on a full buffer
    clear_cycle("clr3");
    step("full_a", 1, 1, 16'h0100, 0, '0, 0, '0);
    step("full_b", 1, 1, 16'h0200, 0, '0, 0, '0);
    step("full_as", 1, 1, 16'h0500, 0, '0, 1, '0);
    chk("full_as_count", 32'(wbuf_count), 32'd2);
    chk("full_as_err",   32'(wbuf_err),   32'd0);
    // Accept and switch together on an empty buffer
    clear_cycle("clr4");
    step("empty_as", 1, 1, 16'h0700, 0, '0, 1, '0);
    chk("empty_as_count", 32'(wbuf_count), 32'd1);
    chk("empty_as_err",   32'(wbuf_err),   32'd1);

    // Positive saturation
    clear_cycle("clr5");
    step("psat_load", 1, 1, 16'h7F00, 0, '0,       0, '0);
    step("psat_sw",   1, 0, '0,       0, '0,       1, '0);
    step("psat_data", 1, 0, '0,       1, 16'h7F00, 0, '0);
    step("psat_mac",  1, 0, '0,       0, '0,       0, 16'h7000);
    chk("psat_result", 32'(psum_out), 32'h7FFF);
    chk("psat_flag",   32'(sat_flag), 32'h1);
    // Negative saturation
    clear_cycle("clr6");
    step("nsat_load", 1, 1, 16'h7F00, 0, '0,       0, '0);
    step("nsat_sw",   1, 0, '0,       0, '0,       1, '0);
    step("nsat_data", 1, 0, '0,       1, 16'h8000, 0, '0);
    step("nsat_mac",  1, 0, '0,       0, '0,       0, 16'h8000);
    chk("nsat_result", 32'(psum_out), 32'h8000);
    chk("nsat_flag",   32'(sat_flag), 32'h1);

    // Hold data_out while valid_in is low; other strobes keep flowing
    step("hold_a", 1, 1, 16'h1234, 1, 16'h0ABC, 0, '0);
    step("hold_b", 1, 0, '0,       0, 16'h5555, 1, '0);
    step("hold_c", 1, 1, 16'h4321, 0, 16'hAAAA, 0, '0);
    chk("hold_data",   32'(data_out),     32'h0ABC);
    chk("hold_valid",  32'(valid_out),    32'h0);
    chk("hold_accept", 32'(accept_w_out), 32'h1);

    // Asynchronous reset in the middle of a load
    clear_cycle("clr7");
    step("ar_load", 1, 1, 16'h0900, 1, 16'h0100, 0, '0);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    chk("async_rst_count", 32'(wbuf_count), 32'd0);
    chk("async_rst_wout",  32'(weight_out), 32'd0);
    rst = 1'b0;
    step("ar_switch", 1, 0, '0, 0, '0, 1, '0);
    chk("ar_switch_err", 32'(wbuf_err), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] rp;
      case ($urandom_range(3))
        0:       rp = 16'h7FFF;
        1:       rp = 16'h8000;
        default: rp = DW'($urandom);
      endcase
      step("rand", ($urandom_range(19) != 0), ($urandom_range(9) < 3), DW'($urandom),
           ($urandom_range(1) == 1), DW'($urandom), ($urandom_range(9) < 2), rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_pe_v2.md
SYSTOLIC_PE_V2 -- requirements
Module: systolic_pe_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the signed two's-complement width of all data/weight/psum paths.
REQ-002 SHALL have parameter FRAC_BITS, default 8, meaning the fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 SHALL have parameter WBUF_DEPTH, default 2, range 1..8, meaning the number of background weight slots.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  in  1  synchronous enable; low clears all state as reset does.
REQ-007 SHALL have ports psum_in, weight_in  in  DATA_WIDTH  north partial sum and weight.
REQ-008 SHALL have port accept_w_in  in  1  north weight-valid strobe.
REQ-009 SHALL have ports data_in  in  DATA_WIDTH, valid_in  in  1, switch_in  in  1  west activation, activation-valid, weight-switch.
REQ-010 SHALL have ports psum_out, weight_out  out  DATA_WIDTH, accept_w_out  out  1  south.
REQ-011 SHALL have ports data_out  out  DATA_WIDTH, valid_out  out  1, switch_out  out  1  east.
REQ-012 SHALL have port wbuf_count  out  $clog2(WBUF_DEPTH+1)  number of loaded background slots.
REQ-013 SHALL have port sat_flag  out  1  sticky arithmetic-saturation flag.
REQ-014 SHALL have port wbuf_err  out  1  sticky flag: weight dropped on full buffer, or switch on empty buffer.

Function
REQ-015 SHALL register every output; all outputs are the result of the previous cycle's inputs (latency 1).
REQ-016 SHALL forward valid_in->valid_out, switch_in->switch_out, accept_w_in->accept_w_out every enabled cycle.
REQ-017 SHALL load data_out <= data_in when valid_in=1, hold data_out otherwise.
REQ-018 SHALL drive weight_out <= weight_in when accept_w_in=1, else 0.
REQ-019 SHALL hold background weights in a circular buffer with write pointer, read pointer and count 0..WBUF_DEPTH; pointers wrap WBUF_DEPTH-1 -> 0.
REQ-020 SHALL, on accept_w_in with count<WBUF_DEPTH, write weight_in to the write slot, advance the write pointer, increment count.
REQ-021 SHALL, on accept_w_in with count=WBUF_DEPTH and no switch in the same cycle, drop the weight, leave the buffer unchanged and set wbuf_err.
REQ-022 SHALL, on switch_in with count>0, copy the read slot into the active weight, advance the read pointer, decrement count; the new weight is used from the next cycle.
REQ-023 SHALL, on switch_in with count=0, keep the active weight unchanged and set wbuf_err.
REQ-024 SHALL, on simultaneous accept and switch with count=WBUF_DEPTH, accept the write (the slot freed by the switch); count stays unchanged.
REQ-025 SHALL, on simultaneous accept and switch with count=0, accept the write, leave the active weight unchanged, set wbuf_err; count becomes 1.
REQ-026 SHALL compute product = (data_out * active_weight) at 2*DATA_WIDTH, arithmetic shift right FRAC_BITS (truncate toward -inf), saturate to DATA_WIDTH.
REQ-027 SHALL compute psum_out <= sat(product + psum_in) at DATA_WIDTH+1 bits, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-028 SHALL set sat_flag when either saturation stage clamps; sat_flag and wbuf_err clear only on reset or en=0.

Reset
REQ-029 SHALL, on rst=1 (async) or en=0 (sync), set all outputs, the active weight, all slots, pointers and count to 0.
REQ-030 SHALL, on reset mid-load or mid-switch, discard the partial buffer contents; no weight survives reset.

Verification
REQ-031 Q8.8: load 0x0200 (2.0), switch, data_in=0x0180 (1.5) valid, psum_in=0x0100 -> psum_out=0x0400 two cycles after data_in, sat_flag=0.
REQ-032 WBUF_DEPTH=2: load 0x0100, 0x0200, 0x0300 back-to-back -> third dropped, wbuf_count=2, wbuf_err=1; two switches yield weights 0x0100 then 0x0200.
REQ-033 Switch with count=0 -> active weight unchanged, wbuf_err=1; accept+switch when full -> count stays 2, wbuf_err stays 0.
REQ-034 data 0x7F00 x weight 0x7F00, psum_in 0x7000 -> psum_out=0x7FFF, sat_flag=1; data 0x8000 x 0x7F00, psum_in 0x8000 -> psum_out=0x8000.
REQ-035 Assert rst asynchronously between clock edges mid-load -> all outputs 0 immediately; wbuf_count=0; a following switch sets wbuf_err.
REQ-036 valid_in=0 with changing data_in -> data_out holds its last value, valid_out=0, switch_out/accept_w_out still forwarded.
